// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: bridges the cart mapper's combinational ROM lookups to SDRAM
// through a single line buffer, and forwards ROM download bytes into SDRAM.
module cart_rom_fetch #(
  parameter int ADDR_W     = 25,
  parameter int LINE_BYTES = 8,
  parameter int MEM_W      = 8 * LINE_BYTES
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pclk0,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              cart_read,
  input  logic [31:0]       cart_size,
  output logic [7:0]        rom_din,
  output logic              rom_wait,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            state, state_nx;
  logic [MEM_W-1:0]  line_buf;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              pend_wr;     // write latched during a read, issued after it
  logic              dl_q;
  logic [7:0]        rom_din_r;
  logic              rom_wait_r;

  // Lookups are evaluated every clock, so the bus strobe carries no extra information.
  logic unused_pclk0;
  assign unused_pclk0 = pclk0;

  logic [31:0]  addr32;
  logic         oor;
  logic         hit;
  logic         rd_miss;
  logic [OFF+2:0] sel;
  logic [7:0]   hit_byte;
  logic         wr_accept;
  logic         wr_in_line;

  assign addr32     = 32'(rom_address);
  assign oor        = addr32 >= cart_size;
  assign hit        = line_valid && (tag == rom_address[ADDR_W-1:OFF]);
  assign rd_miss    = cart_read && !ioctl_download && !oor && !hit;
  assign sel        = {rom_address[OFF-1:0], 3'b000};
  assign hit_byte   = line_buf[sel +: 8];
  // A second strobe while a write is still outstanding is dropped.
  assign wr_accept  = ioctl_wr && !ioctl_wait;
  assign wr_in_line = line_valid && (wr_addr[ADDR_W-1:OFF] == tag);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state: writes win over reads in IDLE; a fetch in flight always completes.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (pend_wr || wr_accept) state_nx = S_WR;
        else if (rd_miss)         state_nx = S_RD;
      end
      S_RD:    if (mem_ack) state_nx = S_IDLE;
      S_WR:    if (mem_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory-side and handshake outputs decoded from state; request is level until the ack.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ioctl_wait = pend_wr;
    case (state)
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
      end
      S_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        ioctl_wait = 1'b1;
      end
      default: ;
    endcase
    rom_din  = ioctl_download ? 8'hFF : rom_din_r;
    rom_wait = rom_wait_r && !ioctl_download;
  end

  // Line buffer, pending write, and the registered byte presented to the mapper.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_buf   <= '0;
      tag        <= '0;
      line_valid <= 1'b0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pend_wr    <= 1'b0;
      dl_q       <= 1'b0;
      rom_din_r  <= 8'hFF;
      rom_wait_r <= 1'b0;
    end else begin
      dl_q <= ioctl_download;

      if (wr_accept) begin
        wr_addr <= ioctl_addr;
        wr_data <= ioctl_data;
      end
      if (wr_accept && state == S_RD)                pend_wr <= 1'b1;
      else if (state == S_IDLE && state_nx == S_WR)  pend_wr <= 1'b0;

      if (state == S_IDLE && state_nx == S_RD)
        rd_addr <= {rom_address[ADDR_W-1:OFF], {OFF{1'b0}}};

      if (state == S_RD && mem_ack) begin
        line_buf   <= mem_rdata;
        tag        <= rd_addr[ADDR_W-1:OFF];
        line_valid <= 1'b1;
      end
      // A byte written into the buffered line makes the copy stale.
      if (state == S_WR && mem_ack && wr_in_line) line_valid <= 1'b0;
      // A new download may replace the whole image.
      if (ioctl_download && !dl_q) line_valid <= 1'b0;

      if (ioctl_download || oor) rom_din_r <= 8'hFF;
      else if (hit)              rom_din_r <= hit_byte;

      // Wait is only re-evaluated between memory transactions.
      if (state == S_IDLE) rom_wait_r <= rd_miss;
    end
  end

endmodule
